// File: rtl/dbg_trace_serializer.sv
// Debug trace serializer: captures a {PC, data-memory-out} word pair on a
// valid/ready handshake and shifts both words out MSB-first on two pins,
// preceded by a one-bit-period start marker and followed by GAP idle periods.
//
// Handshake: a capture is accepted on any rising edge where cap_valid and
// cap_ready are both high; cap_ready is high exactly while the FSM is IDLE.
// A request seen while busy is never queued, it only bumps drop_cnt.
module dbg_trace_serializer #(
   parameter int WIDTH = 32,
   parameter int DIV   = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cap_valid,
   output logic             cap_ready,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [WIDTH-1:0] dm_in,
   output logic             ser_pc,
   output logic             ser_dm,
   output logic             ser_frame,
   output logic             ser_strobe,
   output logic [7:0]       drop_cnt,
   output logic [1:0]       dbg_state
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = ($clog2(WIDTH + 1) > 0) ? $clog2(WIDTH + 1) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   // Only reachable when GAP > 0; with GAP == 0 the GAP state is never entered.
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t           state_q, state_nx;
   logic [DW-1:0]    div_q, div_nx;
   logic [BW-1:0]    bit_q, bit_nx;
   logic [GW-1:0]    gap_q, gap_nx;
   logic [WIDTH-1:0] pc_sr, pc_nx;
   logic [WIDTH-1:0] dm_sr, dm_nx;

   assign cap_ready = (state_q == S_IDLE);
   assign dbg_state = state_q;

   // FSM state, bit-period counters and shift registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         pc_sr   <= '0;
         dm_sr   <= '0;
      end else begin
         state_q <= state_nx;
         div_q   <= div_nx;
         bit_q   <= bit_nx;
         gap_q   <= gap_nx;
         pc_sr   <= pc_nx;
         dm_sr   <= dm_nx;
      end
   end

   // Next-state logic: each state is timed in whole bit periods of DIV cycles.
   always_comb begin
      state_nx = state_q;
      div_nx   = div_q;
      bit_nx   = bit_q;
      gap_nx   = gap_q;
      pc_nx    = pc_sr;
      dm_nx    = dm_sr;
      case (state_q)
         S_IDLE: begin
            if (cap_valid) begin
               state_nx = S_START;
               div_nx   = '0;
               bit_nx   = '0;
               gap_nx   = '0;
               pc_nx    = pc_in;
               dm_nx    = dm_in;
            end
         end
         S_START: begin
            if (div_q == DIV_LAST) begin
               state_nx = S_SHIFT;
               div_nx   = '0;
            end else begin
               div_nx = div_q + DIV_ONE;
            end
         end
         S_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_nx = '0;
               pc_nx  = pc_sr << 1;
               dm_nx  = dm_sr << 1;
               bit_nx = bit_q + BIT_ONE;
               if (bit_q == BIT_LAST) begin
                  state_nx = (GAP == 0) ? S_IDLE : S_GAP;
               end
            end else begin
               div_nx = div_q + DIV_ONE;
            end
         end
         S_GAP: begin
            if (div_q == DIV_LAST) begin
               div_nx = '0;
               if (gap_q == GAP_LAST) begin
                  state_nx = S_IDLE;
               end else begin
                  gap_nx = gap_q + GAP_ONE;
               end
            end else begin
               div_nx = div_q + DIV_ONE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Serial outputs are registered from the next-state view so they line up
   // with the state they describe and never glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ser_frame  <= 1'b0;
         ser_pc     <= 1'b0;
         ser_dm     <= 1'b0;
         ser_strobe <= 1'b0;
      end else begin
         ser_frame  <= (state_nx == S_START) || (state_nx == S_SHIFT);
         ser_pc     <= (state_nx == S_START) || ((state_nx == S_SHIFT) && pc_nx[WIDTH-1]);
         ser_dm     <= (state_nx == S_START) || ((state_nx == S_SHIFT) && dm_nx[WIDTH-1]);
         ser_strobe <= (state_nx == S_SHIFT) && (div_nx == DIV_LAST);
      end
   end

   // Saturating count of requests that arrive while a frame is in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt <= 8'd0;
      end else if (cap_valid && (state_q != S_IDLE) && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_dbg_trace_serializer.sv
// Bench for dbg_trace_serializer: one instance with DIV=4/GAP=1 and one with
// DIV=1/GAP=0, checked against a per-cycle model derived from frame timing rules.
module tb_dbg_trace_serializer;

   localparam int W      = 32;
   localparam int DA     = 4;
   localparam int GA     = 1;
   localparam int DB     = 1;
   localparam int GB     = 0;
   localparam int FRAME_A = DA * (1 + W);
   localparam int BUSY_A  = DA * (1 + W + GA);

   logic         clk = 1'b0;
   logic         reset;
   logic         a_valid, a_ready, a_ser_pc, a_ser_dm, a_frame, a_strobe;
   logic [W-1:0] a_pc, a_dm;
   logic [7:0]   a_drop;
   logic [1:0]   a_state;
   logic         b_valid, b_ready, b_ser_pc, b_ser_dm, b_frame, b_strobe;
   logic [W-1:0] b_pc, b_dm;
   logic [7:0]   b_drop;
   logic [1:0]   b_state;

   int errors = 0;
   int checks = 0;

   // clock / reset
   always #5 clk = ~clk;

   dbg_trace_serializer #(.WIDTH(W), .DIV(DA), .GAP(GA)) u_dut_a (
      .clk(clk), .reset(reset), .cap_valid(a_valid), .cap_ready(a_ready),
      .pc_in(a_pc), .dm_in(a_dm), .ser_pc(a_ser_pc), .ser_dm(a_ser_dm),
      .ser_frame(a_frame), .ser_strobe(a_strobe), .drop_cnt(a_drop), .dbg_state(a_state)
   );

   dbg_trace_serializer #(.WIDTH(W), .DIV(DB), .GAP(GB)) u_dut_b (
      .clk(clk), .reset(reset), .cap_valid(b_valid), .cap_ready(b_ready),
      .pc_in(b_pc), .dm_in(b_dm), .ser_pc(b_ser_pc), .ser_dm(b_ser_dm),
      .ser_frame(b_frame), .ser_strobe(b_strobe), .drop_cnt(b_drop), .dbg_state(b_state)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference: expected {ready, frame, pc, dm, strobe} t cycles after the accept edge.
   function automatic logic [4:0] model_out(input int div, input int gap, input int t,
                                            input logic [W-1:0] pc, input logic [W-1:0] dm);
      logic f, p, d, s, r;
      int   b;
      f = (t >= 1) && (t <= div * (1 + W));
      r = (t < 1) || (t > div * (1 + W + gap));
      p = 1'b0;
      d = 1'b0;
      s = 1'b0;
      if (f && t <= div) begin
         p = 1'b1;
         d = 1'b1;
      end else if (f) begin
         b = (t - div - 1) / div;
         p = pc[W-1-b];
         d = dm[W-1-b];
         s = ((t - div) % div) == 0;
      end
      return {r, f, p, d, s};
   endfunction

   task automatic wait_idle_a();
      int n = 0;
      while (a_ready !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_idle_a timeout ready=%b exp=1", a_ready);
      end
   endtask

   task automatic wait_idle_b();
      int n = 0;
      while (b_ready !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      checks++;
      if (b_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_idle_b timeout ready=%b exp=1", b_ready);
      end
   endtask

   // Send one frame on instance A and check every cycle through return to idle.
   task automatic run_frame_a(input logic [W-1:0] pc, input logic [W-1:0] dm,
                              input bit tamper, input string name);
      int           mism = 0;
      int           first_t = -1;
      int           frame_cnt = 0;
      int           strobe_cnt = 0;
      int           ready_lo = 0;
      logic [W-1:0] pc_rx = '0;
      logic [W-1:0] dm_rx = '0;
      logic [4:0]   o, e;
      logic [4:0]   first_o = '0;
      logic [4:0]   first_e = '0;
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before_accept got=%b exp=1", name, a_ready);
      end
      a_valid = 1'b1;
      a_pc    = pc;
      a_dm    = dm;
      tick();
      a_valid = 1'b0;
      for (int t = 1; t <= BUSY_A + 1; t++) begin
         o = {a_ready, a_frame, a_ser_pc, a_ser_dm, a_strobe};
         e = model_out(DA, GA, t, pc, dm);
         if (o !== e) begin
            mism++;
            if (first_t < 0) begin
               first_t = t;
               first_o = o;
               first_e = e;
            end
         end
         if (a_frame === 1'b1) frame_cnt++;
         if (a_ready === 1'b0) ready_lo++;
         if (a_strobe === 1'b1) begin
            strobe_cnt++;
            pc_rx = {pc_rx[W-2:0], a_ser_pc};
            dm_rx = {dm_rx[W-2:0], a_ser_dm};
         end
         if (tamper && t == DA * 6) begin
            a_pc = '1;
            a_dm = ~dm;
         end
         tick();
      end
      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL %s cycle_model %0d bad cycles, first t=%0d got=%b exp=%b (ready,frame,pc,dm,strobe)",
                  name, mism, first_t, first_o, first_e);
      end
      checks++;
      if (frame_cnt != FRAME_A) begin
         errors++;
         $display("FAIL %s frame_len got=%0d exp=%0d", name, frame_cnt, FRAME_A);
      end
      checks++;
      if (strobe_cnt != W) begin
         errors++;
         $display("FAIL %s strobe_count got=%0d exp=%0d", name, strobe_cnt, W);
      end
      checks++;
      if (pc_rx !== pc) begin
         errors++;
         $display("FAIL %s pc_rebuilt got=%h exp=%h", name, pc_rx, pc);
      end
      checks++;
      if (dm_rx !== dm) begin
         errors++;
         $display("FAIL %s dm_rebuilt got=%h exp=%h", name, dm_rx, dm);
      end
      checks++;
      if (ready_lo != BUSY_A) begin
         errors++;
         $display("FAIL %s ready_low_len got=%0d exp=%0d", name, ready_lo, BUSY_A);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_pc = '0; a_dm = '0; b_pc = '0; b_dm = '0;
      repeat (3) tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({a_ready, a_frame, a_ser_pc, a_ser_dm, a_strobe, a_drop} !== {5'b10000, 8'd0}) begin
            errors++;
            $display("FAIL reset_idle_a got=%b/%0d exp=10000/0", {a_ready, a_frame, a_ser_pc, a_ser_dm, a_strobe}, a_drop);
         end
         checks++;
         if ({b_ready, b_frame, b_ser_pc, b_ser_dm, b_strobe, b_drop} !== {5'b10000, 8'd0}) begin
            errors++;
            $display("FAIL reset_idle_b got=%b/%0d exp=10000/0", {b_ready, b_frame, b_ser_pc, b_ser_dm, b_strobe}, b_drop);
         end
      end
   endtask

   task automatic test_basic_frame();
      wait_idle_a();
      run_frame_a(32'h8000_0001, 32'h0000_00FF, 1'b0, "basic");
   endtask

   task automatic test_drop_saturate();
      int acc[$];
      int exp_acc[$];
      int busy = 0;
      int drops = 0;
      int exp_drop;
      wait_idle_a();
      a_valid = 1'b1;
      for (int n = 0; n < 300; n++) begin
         exp_drop = (drops > 255) ? 255 : drops;
         if (n == 50 || n == 136 || n == 200 || n == 260 || n == 299) begin
            checks++;
            if (a_drop !== 8'(exp_drop)) begin
               errors++;
               $display("FAIL drop_cnt n=%0d got=%0d exp=%0d", n, a_drop, exp_drop);
            end
         end
         if (a_ready === 1'b1) acc.push_back(n);
         if (busy == 0) begin
            exp_acc.push_back(n);
            busy = BUSY_A;
         end else begin
            drops++;
            busy--;
         end
         tick();
      end
      a_valid = 1'b0;
      checks++;
      if (a_drop !== 8'd255) begin
         errors++;
         $display("FAIL drop_saturated got=%0d exp=255", a_drop);
      end
      checks++;
      if (acc.size() != exp_acc.size()) begin
         errors++;
         $display("FAIL accept_count got=%0d exp=%0d", acc.size(), exp_acc.size());
      end else begin
         for (int i = 0; i < acc.size(); i++) begin
            checks++;
            if (acc[i] != exp_acc[i]) begin
               errors++;
               $display("FAIL accept_time idx=%0d got=%0d exp=%0d", i, acc[i], exp_acc[i]);
            end
         end
      end
      wait_idle_a();
   endtask

   task automatic test_reset_midframe();
      wait_idle_a();
      a_valid = 1'b1;
      a_pc    = $urandom;
      a_dm    = $urandom;
      tick();
      a_valid = 1'b0;
      repeat (DA + 10 * DA + 1) tick();
      checks++;
      if (a_frame !== 1'b1) begin
         errors++;
         $display("FAIL midframe_active frame got=%b exp=1", a_frame);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({a_ready, a_frame, a_ser_pc, a_ser_dm, a_strobe} !== 5'b10000) begin
         errors++;
         $display("FAIL async_reset_outputs got=%b exp=10000", {a_ready, a_frame, a_ser_pc, a_ser_dm, a_strobe});
      end
      checks++;
      if (a_drop !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_drop got=%0d exp=0", a_drop);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({a_ready, a_frame, a_ser_pc, a_ser_dm, a_strobe} !== 5'b10000) begin
            errors++;
            $display("FAIL no_resume got=%b exp=10000", {a_ready, a_frame, a_ser_pc, a_ser_dm, a_strobe});
         end
      end
      run_frame_a(32'h1234_5678, 32'hCAFE_BABE, 1'b0, "after_reset");
   endtask

   task automatic test_input_hold();
      logic [W-1:0] dm;
      dm = $urandom;
      wait_idle_a();
      run_frame_a(32'h0F0F_0F0F, dm, 1'b1, "input_hold");
   endtask

   task automatic test_random_frames();
      logic [W-1:0] pc, dm;
      for (int i = 0; i < 3; i++) begin
         pc = $urandom;
         dm = $urandom;
         repeat ($urandom_range(0, 5)) tick();
         wait_idle_a();
         run_frame_a(pc, dm, 1'b0, "random");
      end
   endtask

   task automatic test_back_to_back();
      int           acc[$];
      int           strobes = 0;
      int           first_s = -1;
      int           last_s = -1;
      int           spacing;
      logic [W-1:0] pc, dm;
      logic [W-1:0] pc_rx = '0;
      logic [W-1:0] dm_rx = '0;
      wait_idle_b();
      pc = $urandom;
      dm = $urandom;
      b_pc = pc;
      b_dm = dm;
      b_valid = 1'b1;
      for (int n = 0; n < 60; n++) begin
         if (acc.size() == 1 && b_strobe === 1'b1) begin
            strobes++;
            if (first_s < 0) first_s = n - acc[0];
            last_s = n - acc[0];
            pc_rx = {pc_rx[W-2:0], b_ser_pc};
            dm_rx = {dm_rx[W-2:0], b_ser_dm};
         end
         if (b_ready === 1'b1) acc.push_back(n);
         tick();
         if (acc.size() == 2) break;
      end
      b_valid = 1'b0;
      spacing = (acc.size() == 2) ? (acc[1] - acc[0]) : -1;
      checks++;
      if (spacing != DB * (1 + W + GB) + 1) begin
         errors++;
         $display("FAIL b2b_spacing got=%0d exp=%0d", spacing, DB * (1 + W + GB) + 1);
      end
      checks++;
      if (b_drop !== 8'd33) begin
         errors++;
         $display("FAIL b2b_drop_cnt got=%0d exp=33", b_drop);
      end
      checks++;
      if (strobes != W || first_s != 2 * DB || last_s != DB * (1 + W)) begin
         errors++;
         $display("FAIL b2b_strobes got=%0d first=%0d last=%0d exp=%0d first=%0d last=%0d",
                  strobes, first_s, last_s, W, 2 * DB, DB * (1 + W));
      end
      checks++;
      if (pc_rx !== pc || dm_rx !== dm) begin
         errors++;
         $display("FAIL b2b_data got=%h/%h exp=%h/%h", pc_rx, dm_rx, pc, dm);
      end
      wait_idle_b();
   endtask

   initial begin
      reset   = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_pc = '0; a_dm = '0; b_pc = '0; b_dm = '0;
      test_reset();
      test_basic_frame();
      test_drop_saturate();
      test_reset_midframe();
      test_input_hold();
      test_random_frames();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dbg_trace_serializer.md
Name: dbg_trace_serializer

Overview:
- Transmit side of the pin-level debug trace for the pipelined core.
- Captures a {PC, data-memory-out} word pair on a valid/ready handshake.
- Shifts both words out MSB-first on two 1-bit lines, uo_out[0] and uo_out[1], with a frame flag and a sample strobe, so a bench or logic analyser can rebuild full 32-bit values from single pins.
- Sits between the core's writeback stage and the tt_um top-level output mux.

Parameters:
- WIDTH, 32: bits per captured word.
- DIV, 4: clock cycles per serial bit period; minimum 1.
- GAP, 1: idle bit periods after each frame; 0 allowed.

Ports:
- clk, input, 1: system clock, all state on rising edge.
- reset, input, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- cap_valid, input, 1: capture request from core.
- cap_ready, output, 1: block idle and able to accept.
- pc_in, input, WIDTH: PC word to trace.
- dm_in, input, WIDTH: data-memory output word to trace.
- ser_pc, output, 1: serial PC bit, drives uo_out[0].
- ser_dm, output, 1: serial data-memory bit, drives uo_out[1].
- ser_frame, output, 1: high from start marker through last data bit.
- ser_strobe, output, 1: 1-cycle pulse on the last cycle of each data bit period (sample point).
- drop_cnt, output, 8: saturating count of rejected capture requests.

Behaviour:
- Reset (async assert, takes effect immediately):
  - state IDLE; shift registers, div/bit counters and drop_cnt cleared.
  - ser_pc, ser_dm, ser_frame, ser_strobe = 0.
  - cap_ready = 1 (cap_ready is decoded as state==IDLE).
- States: IDLE -> START -> SHIFT -> GAP -> IDLE. GAP is skipped when GAP=0.
- Accept: on an edge where cap_valid && cap_ready:
  - latch pc_in and dm_in into the shift regs, go to START, div counter = 0.
  - inputs are sampled only at accept; later changes have no effect.
- START:
  - DIV cycles; ser_frame=1, ser_pc=1, ser_dm=1 (start marker); ser_strobe=0.
- SHIFT:
  - ser_frame=1; ser_pc/ser_dm = MSB of the respective shift reg.
  - div counter 0..DIV-1; at DIV-1: ser_strobe=1, both regs shift left (zero fill), bit counter +1.
  - after WIDTH bits -> GAP.
  - DIV=1: strobe is high every SHIFT cycle.
- GAP:
  - GAP*DIV cycles with ser_frame=0, data lines 0, strobe 0; then IDLE.
- Outputs are registered. If accept occurs at edge k:
  - ser_frame is high for cycles k+1 .. k+DIV*(1+WIDTH).
  - first strobe at cycle k+2*DIV; last strobe at cycle k+DIV*(1+WIDTH).
  - cap_ready is low for exactly DIV*(1+WIDTH+GAP) cycles.
  - minimum accept-to-accept spacing is DIV*(1+WIDTH+GAP)+1 cycles.
- drop_cnt:
  - +1 on every edge with cap_valid=1 && cap_ready=0.
  - saturates at 255; cleared only by reset.
  - a request in the last GAP cycle is dropped, not queued.
- IDLE: all serial outputs 0; no partial or queued frames exist.
- Reset mid-frame: frame aborts immediately, outputs go 0 asynchronously, and no resume after release. The next accepted capture transmits a complete fresh frame.
- Width rules: counters sized to $clog2(WIDTH+1) and $clog2(DIV) bits (minimum 1); drop_cnt fixed 8 bits.

Test Plan:
1. Reset held 3 cycles, then released with cap_valid=0 -> all serial outputs 0, cap_ready=1, drop_cnt=0; stays idle.
2. DIV=4, GAP=1; accept pc_in=0x80000001, dm_in=0x000000FF:
   - ser_frame high 132 cycles; 32 strobes.
   - ser_pc at strobes = 1, thirty 0s, 1; ser_dm = 24 zeros then 8 ones.
   - cap_ready low 136 cycles.
3. cap_valid held high 300 cycles from idle (DIV=4, GAP=1) -> accepts at t=0, 137, 274; drop_cnt saturates at 255 and holds.
4. Reset pulsed during SHIFT at bit 10 -> ser_frame, ser_pc, ser_dm drop to 0 before the next edge; cap_ready=1. A new capture of 0x12345678/0xCAFEBABE serializes completely and correctly.
5. Accept pc_in=0x0F0F0F0F, then force pc_in=0xFFFFFFFF during SHIFT -> strobe-sampled PC still reads 0x0F0F0F0F.
6. DIV=1, GAP=0; two back-to-back requests -> strobe every cycle for 32 cycles; second accept exactly 34 cycles after the first; drop_cnt=33 if cap_valid is held continuously.
